csa_resolver: RTL and testbench
===============================

Name: csa_resolver

Overview:
- Consumer end of the carry-save adder path: accepts a redundant carry-save pair (sum vector, carry vector) and resolves it into a plain binary value.
- Uses a multi-cycle chunked carry-propagate add, CHUNK bits per clock, so no full-width ripple chain sits on the critical path.
- Sits directly downstream of the 3-operand carry-save stage. Valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, width of in_sum and in_carry.
- CHUNK, 8, bits resolved per clock. Legal range 1..WIDTH+2; does not need to divide WIDTH+2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_sum  input  WIDTH  carry-save sum vector; bit i has weight 2^i.
- in_carry  input  WIDTH  carry-save carry vector; bit i has weight 2^(i+1).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_value  output  WIDTH+2  in_sum + 2*in_carry, zero-extended, exact.
- out_ovf  output  1  present only with CSA_RES_OVF_EN (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, so in_ready=1.
  - out_valid=0, out_value=0, out_ovf=0.
  - chunk counter=0, carry register=0, operand registers=0.
- Derived constants:
  - N = WIDTH+2.
  - NCHUNK = ceil(N/CHUNK). Default NCHUNK=5.
- Operand capture: on accept (in_valid & in_ready at a rising edge), register:
  - A = {2'b0, in_sum}
  - B = {1'b0, in_carry, 1'b0}
  - Clear carry register and chunk index k.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept, go to BUSY.
  - BUSY: in_ready=0. Each cycle computes chunk k:
    - {c, R[k*CHUNK +: CHUNK]} = A chunk + B chunk + carry reg; store c in the carry register.
    - Last chunk is truncated to N bits; its carry-out is discarded, because the result always fits in N bits.
    - After chunk NCHUNK-1, go to DONE.
  - DONE: out_valid=1, out_value=R, held stable. When out_ready=1 at an edge, go to IDLE and clear out_valid.
- Latency:
  - out_valid rises NCHUNK clocks after the accepting edge (default 5).
  - Throughput is one result per NCHUNK+2 cycles minimum (accept, NCHUNK BUSY cycles, DONE handshake).
- Boundary conditions:
  - in_valid while BUSY or DONE is ignored, and the operands are not sampled.
  - out_ready while IDLE or BUSY has no effect.
  - in_valid and out_ready both high in DONE: the result completes, and the new operand is not accepted until the IDLE cycle.
  - out_value is only meaningful while out_valid=1; it holds its last value otherwise.
  - Reset mid-operation: immediate return to reset values, the partial result is discarded, and nothing is emitted after release.
  - Carry between chunks must propagate correctly across every chunk boundary, including the partial top chunk.
- Arithmetic is unsigned.

Optional Feature:
- Macro: CSA_RES_OVF_EN.
- Defined:
  - out_ovf port exists.
  - Registered with out_value: out_ovf = |out_value[WIDTH+1:WIDTH], i.e. the result does not fit in WIDTH bits.
  - Valid only with out_valid; reset 0.
- Undefined: no out_ovf port and no associated logic. All other behaviour is identical.

Test Plan:
1. Basic resolve: sum=0x00000005, carry=0x00000003, accept at edge t → out_valid=1 at t+5, out_value=0x00000000B, out_ovf=0.
2. Cross-chunk carry: sum=0x000000FF, carry=0x00000001 → out_value=0x000000101. Also sum=0x00FFFFFF, carry=0x00000001 → 0x001000001, exercising carry through three chunk boundaries.
3. Full-scale: sum=0xFFFFFFFF, carry=0xFFFFFFFF → out_value=0x2FFFFFFFD, out_ovf=1 (with CSA_RES_OVF_EN).
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_value and out_valid stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 for 1 cycle → next cycle out_valid=0, in_ready=1. The following operand (sum=1, carry=0) gives 0x1.
5. Reset mid-op: accept sum=0x12345678, carry=0x11111111, assert rst_n=0 on the 2nd BUSY cycle → outputs go to reset values asynchronously. After release: in_ready=1, and out_valid stays 0 for 20 cycles with no input.
6. Back-to-back: in_valid and out_ready held high, operands 0x10/0x08 then 0x20/0x01 → results 0x20 then 0x22, with no operand lost or duplicated.

Source files
------------

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save (sum, carry) pair into binary, CHUNK bits per clock.
// Optional CSA_RES_OVF_EN adds out_ovf (result does not fit in WIDTH bits).
module csa_resolver #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_sum,
   input  logic [WIDTH-1:0] in_carry,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH+1:0] out_value
`ifdef CSA_RES_OVF_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int N      = WIDTH + 2;
   localparam int NCHUNK = (N + CHUNK - 1) / CHUNK;
   localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [N-1:0]    a;
   logic [N-1:0]    b;
   logic [N-1:0]    r;
   logic [KW-1:0]   k;
   logic            cy;

   logic [CHUNK-1:0] a_ch;
   logic [CHUNK-1:0] b_ch;
   logic [CHUNK:0]   s;
   logic [N-1:0]     r_nxt;
   logic             last;

   // Bits past N in the top chunk read as zero, so a partial chunk needs no special case.
   always_comb begin
      a_ch = '0;
      b_ch = '0;
      for (int j = 0; j < N; j++) begin
         if (KW'(j / CHUNK) == k) begin
            a_ch[j % CHUNK] = a[j];
            b_ch[j % CHUNK] = b[j];
         end
      end
      s = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, cy};
      r_nxt = r;
      for (int j = 0; j < N; j++) begin
         if (KW'(j / CHUNK) == k) r_nxt[j] = s[j % CHUNK];
      end
   end

   assign last = (k == KW'(NCHUNK - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_value <= '0;
         a         <= '0;
         b         <= '0;
         r         <= '0;
         k         <= '0;
         cy        <= 1'b0;
`ifdef CSA_RES_OVF_EN
         out_ovf   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a        <= {2'b00, in_sum};
                  b        <= {1'b0, in_carry, 1'b0};
                  k        <= '0;
                  cy       <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               r  <= r_nxt;
               cy <= s[CHUNK];
               k  <= k + 1'b1;
               if (last) begin
                  k         <= '0;
                  out_valid <= 1'b1;
                  out_value <= r_nxt;
`ifdef CSA_RES_OVF_EN
                  out_ovf   <= |r_nxt[N-1:WIDTH];
`endif
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed and random checks of csa_resolver against
// a plain-arithmetic model (sum + 2*carry).
module tb_csa_resolver;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_sum;
   logic [31:0] in_carry;
   logic        out_valid;
   logic        out_ready;
   logic [33:0] out_value;
`ifdef CSA_RES_OVF_EN
   logic        out_ovf;
`endif

   int checks = 0;
   int errors = 0;

   localparam int LAT = 5;

   csa_resolver #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value)
`ifdef CSA_RES_OVF_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [33:0] model(input logic [31:0] s, input logic [31:0] c);
      logic [33:0] r;
      r = 34'(s) + 34'(c) * 34'd2;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [31:0] s, input logic [31:0] c,
                         input int hold, input string tag);
      int n;
      logic [33:0] exp;
      logic [33:0] held;
      exp      = model(s, c);
      in_sum   = s;
      in_carry = c;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_sum   = $urandom;
      in_carry = $urandom;
      chk({tag, "_busy"}, 64'(in_ready), 64'd0);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1; n++;
      end
      chk({tag, "_lat"}, 64'(n), 64'(LAT));
      chk({tag, "_val"}, 64'(out_value), 64'(exp));
`ifdef CSA_RES_OVF_EN
      chk({tag, "_ovf"}, 64'(out_ovf), 64'(|exp[33:32]));
`endif
      held = out_value;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_sum   = $urandom;
         in_carry = $urandom;
         @(posedge clk); #1;
         chk({tag, "_hv"}, 64'(out_valid), 64'd1);
         chk({tag, "_hr"}, 64'(in_ready), 64'd0);
         chk({tag, "_hval"}, 64'(out_value), 64'(held));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_clr"}, 64'(out_valid), 64'd0);
      chk({tag, "_idle"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [31:0] bs [2];
      logic [31:0] bc [2];
      logic [33:0] exp_q [$];
      logic [33:0] cap;
      logic        acc;
      logic        hs;
      int          sent;
      int          got;
      int          cyc;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sum    = '0;
      in_carry  = '0;
      out_ready = 1'b0;
      #12;
      chk("rst_rdy", 64'(in_ready), 64'd1);
      chk("rst_ov", 64'(out_valid), 64'd0);
      chk("rst_val", 64'(out_value), 64'd0);
`ifdef CSA_RES_OVF_EN
      chk("rst_ovf", 64'(out_ovf), 64'd0);
`endif
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(32'h0000_0005, 32'h0000_0003, 0, "basic");
      run_op(32'h0000_00FF, 32'h0000_0001, 0, "x1");
      run_op(32'h00FF_FFFF, 32'h0000_0001, 0, "x3");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "full");
      run_op(32'hFFFF_FFFF, 32'h0000_0000, 0, "top0");
      run_op(32'h0000_0000, 32'h8000_0000, 0, "top1");
      run_op(32'hA5A5_5A5A, 32'h0F0F_F0F0, 10, "bp");
      run_op(32'h0000_0001, 32'h0000_0000, 0, "after");

      for (int i = 0; i < 20; i++)
         run_op($urandom, $urandom, 0, "rnd");

      // Reset on the second BUSY cycle.
      in_sum   = 32'h1234_5678;
      in_carry = 32'h1111_1111;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rdy", 64'(in_ready), 64'd1);
      chk("mid_ov", 64'(out_valid), 64'd0);
      chk("mid_val", 64'(out_value), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rel_rdy", 64'(in_ready), 64'd1);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         chk("rel_quiet", 64'(out_valid), 64'd0);
      end

      // Back-to-back with in_valid and out_ready held high.
      bs[0] = 32'h10; bc[0] = 32'h08;
      bs[1] = 32'h20; bc[1] = 32'h01;
      sent = 0; got = 0; cyc = 0;
      in_sum    = bs[0];
      in_carry  = bc[0];
      in_valid  = 1'b1;
      out_ready = 1'b1;
      while (got < 2 && cyc < 100) begin
         acc = in_valid && in_ready;
         hs  = out_valid && out_ready;
         cap = out_value;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            exp_q.push_back(model(bs[sent], bc[sent]));
            sent++;
            if (sent < 2) begin
               in_sum   = bs[sent];
               in_carry = bc[sent];
            end else begin
               in_valid = 1'b0;
            end
         end
         if (hs) begin
            if (exp_q.size() > 0) chk("b2b_val", 64'(cap), 64'(exp_q.pop_front()));
            else chk("b2b_extra", 64'(cap), 64'h1_0000_0000_0000);
            got++;
         end
      end
      chk("b2b_got", 64'(got), 64'd2);
      chk("b2b_sent", 64'(sent), 64'd2);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("b2b_dup", 64'(out_valid), 64'd0);
      end
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
